// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and helpers for the LLC-line to memory-burst adaptor.
package line_burst_adaptor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } state_e;

  // Widest address the alignment helper handles.
  localparam int unsigned MaxAddrW = 64;

  function automatic logic [MaxAddrW-1:0] align_addr(input logic [MaxAddrW-1:0] addr,
                                                     input int unsigned         ofs_w);
    logic [MaxAddrW-1:0] mask;
    mask = '1;
    mask = mask << ofs_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/burst_watchdog.sv
// Counts consecutive active cycles without a memory handshake and flags expiry
// on the cycle the count would reach TIMEOUT_CYC.
module burst_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic resp_i,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    assign expired = 1'b0;
    logic unused_wd;
    assign unused_wd = ^{clk, reset_n, active, resp_i};
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = '0;
      if (active && !resp_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign expired = active && !resp_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/line_burst_adaptor.sv
// Bridges single-line LLC transactions to multi-beat memory bursts, with a
// latched write buffer, line-aligned addressing and an optional response watchdog.
module line_burst_adaptor
  import line_burst_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W      = 256,
  parameter int unsigned BURST_W     = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic               err_o,
  output logic               busy_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned OFS_W = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W = $clog2(BEATS);

  if ((LINE_W % BURST_W) != 0 || BEATS < 2 || ADDR_W > MaxAddrW) begin : g_param_check
    $error("line_burst_adaptor: LINE_W must be a multiple (>=2) of BURST_W, ADDR_W <= 64");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  wbuf_q, wbuf_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic               last_beat;
  logic               expired;
  logic [ADDR_W-1:0]  addr_aligned;

  assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));
  assign addr_aligned = ADDR_W'(align_addr(MaxAddrW'(address_i), OFS_W));

  burst_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .active ((state_q == StRd) || (state_q == StWr)),
    .resp_i (resp_i),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Write wins a collision; a held read is picked up after DONE.
        if (write_i) begin
          wbuf_d  = line_i;
          burst_d = line_i[BURST_W-1:0];
          addr_d  = addr_aligned;
          write_d = 1'b1;
          state_d = StWr;
        end else if (read_i) begin
          addr_d  = addr_aligned;
          read_d  = 1'b1;
          state_d = StRd;
        end
      end
      StRd: begin
        if (expired) begin
          read_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (resp_i) begin
          line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            read_d  = 1'b0;
            state_d = StDone;
          end
        end
      end
      StWr: begin
        if (expired) begin
          write_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            write_d = 1'b0;
            state_d = StDone;
          end else begin
            burst_d = wbuf_q[(int'(cnt_q) + 1)*BURST_W +: BURST_W];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = (state_q == StDone);
  assign err_o     = err_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench: stimulus pushes expected addresses, write beats and
// completions; negedge monitors pop and compare as the DUTs present them.
module tb_line_burst_adaptor;

  typedef struct {
    logic         chk;
    logic [511:0] line;
    logic         err;
  } done_t;

  localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
  localparam logic [255:0] L4 = {64'hA4A4_A4A4_A4A4_A4A4, 64'hA3A3_A3A3_A3A3_A3A3,
                                 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1};
  localparam logic [255:0] L5 = {64'h5050_5050_5050_5050, 64'h4040_4040_4040_4040,
                                 64'h3030_3030_3030_3030, 64'h2020_2020_2020_2020};
  localparam logic [511:0] L6 = {128'h4444_0000_4444_0000_4444_0000_4444_0000,
                                 128'h3333_0000_3333_0000_3333_0000_3333_0000,
                                 128'h2222_0000_2222_0000_2222_0000_2222_0000,
                                 128'h1111_0000_1111_0000_1111_0000_1111_0000};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // DUT0: 256/64, watchdog 8
  logic [255:0] line_i0, line_o0;
  logic [31:0]  addr_i0, addr_o0;
  logic         rd_i0, wr_i0, resp_o0, err_o0, busy_o0, rd_o0, wr_o0, resp_i0;
  logic [63:0]  burst_i0, burst_o0;
  // DUT1: 512/128, watchdog off
  logic [511:0] line_i1, line_o1;
  logic [31:0]  addr_i1, addr_o1;
  logic         rd_i1, wr_i1, resp_o1, err_o1, busy_o1, rd_o1, wr_o1, resp_i1;
  logic [127:0] burst_i1, burst_o1;

  line_burst_adaptor #(
    .LINE_W(256), .BURST_W(64), .ADDR_W(32), .TIMEOUT_CYC(8)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .line_i(line_i0), .line_o(line_o0),
    .address_i(addr_i0), .read_i(rd_i0), .write_i(wr_i0), .resp_o(resp_o0),
    .err_o(err_o0), .busy_o(busy_o0), .burst_i(burst_i0), .burst_o(burst_o0),
    .address_o(addr_o0), .read_o(rd_o0), .write_o(wr_o0), .resp_i(resp_i0)
  );

  line_burst_adaptor #(
    .LINE_W(512), .BURST_W(128), .ADDR_W(32), .TIMEOUT_CYC(0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .line_i(line_i1), .line_o(line_o1),
    .address_i(addr_i1), .read_i(rd_i1), .write_i(wr_i1), .resp_o(resp_o1),
    .err_o(err_o1), .busy_o(busy_o1), .burst_i(burst_i1), .burst_o(burst_o1),
    .address_o(addr_o1), .read_o(rd_o1), .write_o(wr_o1), .resp_i(resp_i1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  done_t        q_done0[$];
  logic [31:0]  q_addr0[$];
  logic [63:0]  q_beat0[$];
  done_t        q_done1[$];
  logic [31:0]  q_addr1[$];

  done_t        d0, d1;
  logic         resp_prev0 = 1'b0, req_prev0 = 1'b0;
  logic         resp_prev1 = 1'b0, req_prev1 = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      resp_prev0 = 1'b0;
      req_prev0  = 1'b0;
    end else begin
      if (resp_prev0) check("resp_pulse0", 512'(resp_o0), 512'(0));
      if (resp_o0) begin
        if (q_done0.size() == 0) check("resp_unexpected0", 512'(resp_o0), 512'(0));
        else begin
          d0 = q_done0.pop_front();
          check("err0", 512'(err_o0), 512'(d0.err));
          check("req_drop0", 512'({rd_o0, wr_o0}), 512'(0));
          if (d0.chk) check("line0", 512'(line_o0), d0.line);
        end
      end else if (err_o0) begin
        check("err_stray0", 512'(err_o0), 512'(0));
      end
      if ((rd_o0 || wr_o0) && !req_prev0) begin
        if (q_addr0.size() == 0) check("req_unexpected0", 512'(rd_o0 || wr_o0), 512'(0));
        else check("addr0", 512'(addr_o0), 512'(q_addr0.pop_front()));
      end
      if (wr_o0 && resp_i0) begin
        if (q_beat0.size() == 0) check("beat_unexpected0", 512'(burst_o0), 512'('1));
        else check("wbeat0", 512'(burst_o0), 512'(q_beat0.pop_front()));
      end
      resp_prev0 = resp_o0;
      req_prev0  = rd_o0 || wr_o0;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      resp_prev1 = 1'b0;
      req_prev1  = 1'b0;
    end else begin
      if (resp_prev1) check("resp_pulse1", 512'(resp_o1), 512'(0));
      if (resp_o1) begin
        if (q_done1.size() == 0) check("resp_unexpected1", 512'(resp_o1), 512'(0));
        else begin
          d1 = q_done1.pop_front();
          check("err1", 512'(err_o1), 512'(d1.err));
          if (d1.chk) check("line1", line_o1, d1.line);
        end
      end
      if ((rd_o1 || wr_o1) && !req_prev1) begin
        if (q_addr1.size() == 0) check("req_unexpected1", 512'(rd_o1 || wr_o1), 512'(0));
        else check("addr1", 512'(addr_o1), 512'(q_addr1.pop_front()));
      end
      resp_prev1 = resp_o1;
      req_prev1  = rd_o1 || wr_o1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read0(input logic [31:0] a, input logic [255:0] ln);
    rd_i0   = 1'b1;
    addr_i0 = a;
    tick();
    resp_i0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      burst_i0 = ln[k*64 +: 64];
      tick();
    end
    resp_i0 = 1'b0;
    rd_i0   = 1'b0;
    tick();
  endtask

  task automatic write0(input logic [31:0] a, input logic [255:0] ln, input logic [6:0] pat,
                        input int npat);
    wr_i0   = 1'b1;
    addr_i0 = a;
    line_i0 = ln;
    tick();
    line_i0 = '0;
    addr_i0 = '1;
    for (int k = 0; k < npat; k++) begin
      resp_i0 = pat[k];
      tick();
    end
    resp_i0 = 1'b0;
    wr_i0   = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [255:0] wd_exp;
    int n;
    reset_n = 1'b0;
    {line_i0, addr_i0, rd_i0, wr_i0, burst_i0, resp_i0} = '0;
    {line_i1, addr_i1, rd_i1, wr_i1, burst_i1, resp_i1} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_line0", 512'(line_o0), 512'(0));
    check("rst_burst0", 512'(burst_o0), 512'(0));
    check("rst_addr0", 512'(addr_o0), 512'(0));
    check("rst_flags0", 512'({rd_o0, wr_o0, resp_o0, err_o0, busy_o0}), 512'(0));
    check("rst_line1", line_o1, 512'(0));
    check("rst_flags1", 512'({burst_o1, addr_o1, rd_o1, wr_o1, resp_o1, err_o1, busy_o1}),
          512'(0));
    reset_n = 1'b1;
    tick();

    // Plain read, unaligned address.
    q_addr0.push_back(32'h1234_5660);
    q_done0.push_back('{chk: 1'b1, line: 512'(L1), err: 1'b0});
    read0(32'h1234_5678, L1);

    // Write with gapped handshakes; line_i/address_i scrambled after acceptance.
    q_addr0.push_back(32'h0000_1FE0);
    for (int k = 0; k < 4; k++) q_beat0.push_back(L2[k*64 +: 64]);
    q_done0.push_back('{chk: 1'b0, line: '0, err: 1'b0});
    write0(32'h0000_1FFF, L2, 7'b1011001, 7);

    // Read and write together: write first, held read accepted after DONE.
    q_addr0.push_back(32'h8000_0040);
    for (int k = 0; k < 4; k++) q_beat0.push_back(L2[k*64 +: 64]);
    q_done0.push_back('{chk: 1'b0, line: '0, err: 1'b0});
    q_addr0.push_back(32'h8000_0040);
    q_done0.push_back('{chk: 1'b1, line: 512'(L3), err: 1'b0});
    rd_i0 = 1'b1;
    write0(32'h8000_0040, L2, 7'b0001111, 4);
    check("collide_idle_rd0", 512'({busy_o0, rd_o0}), 512'(0));
    read0(32'h8000_0040, L3);

    // Watchdog: one beat then silence.
    wd_exp        = L3;
    wd_exp[63:0]  = 64'h5555_5555_5555_5555;
    q_addr0.push_back(32'h0000_0040);
    q_done0.push_back('{chk: 1'b1, line: 512'(wd_exp), err: 1'b1});
    rd_i0   = 1'b1;
    addr_i0 = 32'h0000_0040;
    tick();
    resp_i0  = 1'b1;
    burst_i0 = 64'h5555_5555_5555_5555;
    tick();
    resp_i0 = 1'b0;
    n = 0;
    while (!resp_o0 && n < 20) begin
      tick();
      n++;
    end
    check("wd_latency", 512'(n), 512'(8));
    rd_i0 = 1'b0;
    tick();

    // Reset asserted during beat 2 of a write.
    q_addr0.push_back(32'h0000_2000);
    q_beat0.push_back(L4[63:0]);
    q_beat0.push_back(L4[127:64]);
    wr_i0   = 1'b1;
    addr_i0 = 32'h0000_2000;
    line_i0 = L4;
    tick();
    resp_i0 = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_line0", 512'(line_o0), 512'(0));
    check("mid_rst_burst0", 512'(burst_o0), 512'(0));
    check("mid_rst_addr0", 512'(addr_o0), 512'(0));
    check("mid_rst_flags0", 512'({rd_o0, wr_o0, resp_o0, err_o0, busy_o0}), 512'(0));
    resp_i0 = 1'b0;
    wr_i0   = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    q_addr0.push_back(32'h0000_00E0);
    q_done0.push_back('{chk: 1'b1, line: 512'(L5), err: 1'b0});
    read0(32'h0000_00FF, L5);

    // Wide configuration: 512-bit line, 128-bit beats, 64-byte alignment.
    q_addr1.push_back(32'hABCD_EF40);
    q_done1.push_back('{chk: 1'b1, line: L6, err: 1'b0});
    rd_i1   = 1'b1;
    addr_i1 = 32'hABCD_EF7F;
    tick();
    resp_i1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      burst_i1 = L6[k*128 +: 128];
      tick();
    end
    resp_i1 = 1'b0;
    rd_i1   = 1'b0;
    tick();

    repeat (3) tick();
    check("sb_done0_empty", 512'(q_done0.size()), 512'(0));
    check("sb_addr0_empty", 512'(q_addr0.size()), 512'(0));
    check("sb_beat0_empty", 512'(q_beat0.size()), 512'(0));
    check("sb_done1_empty", 512'(q_done1.size()), 512'(0));
    check("sb_addr1_empty", 512'(q_addr1.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
